mem_exc_ctrl: RTL and testbench
===============================

MEM_EXC_CTRL -- requirements
Module: mem_exc_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter NUM_WIN, default 4, number of legal address windows.
REQ-003 SHALL have parameter WIN_BASE, default {0x7f20,0x7f10,0x7f00,0x0000}, packed NUM_WIN*ADDR_W; window i occupies slice i.
REQ-004 SHALL have parameter WIN_LIMIT, default {0x7f23,0x7f1b,0x7f0b,0x2fff}, inclusive upper bounds, same packing.
REQ-005 SHALL have parameter WORD_ONLY, default 4'b0110, per-window flag; sub-word access is illegal.
REQ-006 SHALL have parameter RO_WORD, default 4'b0110, per-window flag; a store to word offset addr[3:2]==2 is illegal.
REQ-007 SHALL have parameter CNT_W, default 8, exception counter width.
REQ-008 clk  in  1  single clock, rising edge.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 in_valid  in  1  M-stage instruction present.
REQ-011 addr  in  ADDR_W  computed memory address.
REQ-012 load_type  in  2  0 none, 1 lw, 2 lh, 3 lb.
REQ-013 store_type  in  2  0 none, 1 sw, 2 sh, 3 sb.
REQ-014 addr_ov  in  1  overflow in address calculation.
REQ-015 prev_exc, prev_code  in  1, 5  exception carried from earlier stages.
REQ-016 pc  in  32  instruction PC.
REQ-017 flush  in  1  discard current M-stage input.
REQ-018 exc_ack  in  1  handler has taken the reported exception.
REQ-019 exc_valid, exc_code  out  1, 5  registered exception report.
REQ-020 bad_vaddr, exc_pc  out  ADDR_W, 32  captured faulting address and PC.
REQ-021 busy  out  1  stall request to upstream while a report is held.
REQ-022 exc_count  out  CNT_W  saturating count of reported exceptions.

Function
REQ-023 In-window: addr lies between WIN_BASE[i] and WIN_LIMIT[i], inclusive, for some i; out-of-window = no window matches.
REQ-024 Access width: lw/sw 4, lh/sh 2, lb/sb 1; misaligned = addr[1:0]!=0 for width 4, addr[0]!=0 for width 2.
REQ-025 Load fault when load_type!=0 and any of: misaligned, addr_ov, out-of-window, width<4 in a WORD_ONLY window; code 4 (AdEL).
REQ-026 Store fault when store_type!=0 and any of: misaligned, addr_ov, out-of-window, width<4 in a WORD_ONLY window, addr[3:2]==2 in an RO_WORD window; code 5 (AdES).
REQ-027 load_type!=0 and store_type!=0 together: code 10 (RI).
REQ-028 Priority: prev_exc (prev_code passed unchanged) > RI > AdEL/AdES.
REQ-029 load_type==0 and store_type==0 with prev_exc=0: no exception.
REQ-030 FSM states IDLE, HOLD.
REQ-031 IDLE: in_valid=1, flush=0 and any exception -> next edge: exc_valid=1, exc_code, bad_vaddr=addr, exc_pc=pc, exc_count+1, go to HOLD; latency 1 cycle.
REQ-032 bad_vaddr SHALL equal addr for codes 4/5/10 and retain its old value when the report comes from prev_exc.
REQ-033 HOLD: busy=1; exc_valid and captured values stay constant; inputs ignored.
REQ-034 HOLD with exc_ack=1 -> next edge: exc_valid=0, go to IDLE; captured values kept.
REQ-035 exc_ack in IDLE SHALL be ignored.
REQ-036 flush=1 in IDLE SHALL suppress capture for that cycle; flush in HOLD SHALL have no effect.
REQ-037 busy SHALL be combinational from state (HOLD), with no input-dependent terms.
REQ-038 exc_count SHALL saturate at all-ones and not wrap.

Reset
REQ-039 reset=0 SHALL immediately force IDLE, exc_valid=0, exc_code=0, bad_vaddr=0, exc_pc=0, exc_count=0, busy=0, including mid-HOLD.
REQ-040 The first capture after reset release SHALL occur at the first rising edge with reset=1.

Verification
REQ-041 lw addr=0x2ffe -> next cycle exc_valid=1, code 4, bad_vaddr=0x2ffe, busy=1.
REQ-042 sw addr=0x7f08 (window 1, RO word) -> code 5; sw 0x7f04 -> no exception; lb 0x7f04 -> code 4.
REQ-043 lh 0x3000 with prev_exc=1, prev_code=12 -> code 12, bad_vaddr unchanged; load and store both nonzero, no prev -> code 10.
REQ-044 In HOLD, apply a new faulting lw with no ack for 3 cycles -> outputs constant; then exc_ack=1 -> exc_valid=0 and busy=0 next cycle.
REQ-045 With CNT_W=2, four exceptions -> exc_count=3; assert reset during HOLD -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/mem_exc_ctrl_if.sv
// M-stage exception bundle: the access under check plus the
// registered exception report returned to the pipeline.
interface mem_exc_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        load_type;
  logic [1:0]        store_type;
  logic              addr_ov;
  logic              prev_exc;
  logic [4:0]        prev_code;
  logic [31:0]       pc;
  logic              flush;
  logic              exc_ack;
  logic              exc_valid;
  logic [4:0]        exc_code;
  logic [ADDR_W-1:0] bad_vaddr;
  logic [31:0]       exc_pc;
  logic              busy;
  logic [CNT_W-1:0]  exc_count;

  modport master (
    output in_valid, addr, load_type, store_type, addr_ov,
    output prev_exc, prev_code, pc, flush, exc_ack,
    input  exc_valid, exc_code, bad_vaddr, exc_pc, busy, exc_count
  );

  modport slave (
    input  in_valid, addr, load_type, store_type, addr_ov,
    input  prev_exc, prev_code, pc, flush, exc_ack,
    output exc_valid, exc_code, bad_vaddr, exc_pc, busy, exc_count
  );
endinterface

// File: rtl/mem_exc_ctrl.sv
// Memory-stage address exception check and one-deep report holder
// that stalls upstream until the handler acknowledges.
module mem_exc_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int NUM_WIN = 4,
  parameter logic [NUM_WIN*ADDR_W-1:0] WIN_BASE = {
    ADDR_W'(32'h7f20), ADDR_W'(32'h7f10),
    ADDR_W'(32'h7f00), ADDR_W'(32'h0000)},
  parameter logic [NUM_WIN*ADDR_W-1:0] WIN_LIMIT = {
    ADDR_W'(32'h7f23), ADDR_W'(32'h7f1b),
    ADDR_W'(32'h7f0b), ADDR_W'(32'h2fff)},
  parameter logic [NUM_WIN-1:0] WORD_ONLY = 4'b0110,
  parameter logic [NUM_WIN-1:0] RO_WORD   = 4'b0110,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           reset,
  mem_exc_ctrl_if.slave m
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [4:0]        code_q, code_d;
  logic [ADDR_W-1:0] bad_q, bad_d;
  logic [31:0]       pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              in_win, wo_hit, ro_hit;
  logic              is_ld, is_st, sub_w, misal;
  logic              ld_flt, st_flt, any_exc;
  logic [4:0]        code_n;
  logic [ADDR_W-1:0] base, lim;

  // Offset compare keeps one unsigned test per window, even at base 0.
  always_comb begin
    in_win = 1'b0;
    wo_hit = 1'b0;
    ro_hit = 1'b0;
    base   = '0;
    lim    = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      base = WIN_BASE[i*ADDR_W +: ADDR_W];
      lim  = WIN_LIMIT[i*ADDR_W +: ADDR_W];
      if ((m.addr - base) <= (lim - base)) begin
        in_win = 1'b1;
        wo_hit = wo_hit | WORD_ONLY[i];
        ro_hit = ro_hit | RO_WORD[i];
      end
    end
  end

  always_comb begin
    is_ld  = m.load_type != 2'd0;
    is_st  = m.store_type != 2'd0;
    misal  = 1'b0;
    sub_w  = 1'b0;
    if (is_ld) begin
      sub_w = m.load_type != 2'd1;
      misal = (m.load_type == 2'd1 && m.addr[1:0] != 2'd0)
           || (m.load_type == 2'd2 && m.addr[0]);
    end else if (is_st) begin
      sub_w = m.store_type != 2'd1;
      misal = (m.store_type == 2'd1 && m.addr[1:0] != 2'd0)
           || (m.store_type == 2'd2 && m.addr[0]);
    end
    ld_flt = is_ld && (misal || m.addr_ov || !in_win
                       || (wo_hit && sub_w));
    st_flt = is_st && (misal || m.addr_ov || !in_win
                       || (wo_hit && sub_w)
                       || (ro_hit && m.addr[3:2] == 2'd2));
    any_exc = m.prev_exc || (is_ld && is_st) || ld_flt || st_flt;
    if (m.prev_exc)          code_n = m.prev_code;
    else if (is_ld && is_st) code_n = 5'd10;
    else if (ld_flt)         code_n = 5'd4;
    else                     code_n = 5'd5;
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    bad_d   = bad_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (m.in_valid && !m.flush && any_exc) begin
          state_d = HOLD;
          valid_d = 1'b1;
          code_d  = code_n;
          pc_d    = m.pc;
          if (!m.prev_exc) bad_d = m.addr;
          if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (m.exc_ack) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      code_q  <= '0;
      bad_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      bad_q   <= bad_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m.exc_valid = valid_q;
  assign m.exc_code  = code_q;
  assign m.bad_vaddr = bad_q;
  assign m.exc_pc    = pc_q;
  assign m.exc_count = cnt_q;
  assign m.busy      = state_q == HOLD;

endmodule

// File: tb/tb_mem_exc_ctrl.sv
// Bench for mem_exc_ctrl: directed cases plus randomized traffic
// against a behavioural exception model, default and CNT_W=2 builds.
module tb_mem_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, addr_ov, prev_exc, flush, exc_ack;
  logic [31:0] addr, pc;
  logic [1:0]  load_type, store_type;
  logic [4:0]  prev_code;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  mem_exc_ctrl_if #(.ADDR_W(32), .CNT_W(8)) bus ();
  mem_exc_ctrl_if #(.ADDR_W(32), .CNT_W(2)) bus2 ();

  assign bus.in_valid   = in_valid;
  assign bus.addr       = addr;
  assign bus.load_type  = load_type;
  assign bus.store_type = store_type;
  assign bus.addr_ov    = addr_ov;
  assign bus.prev_exc   = prev_exc;
  assign bus.prev_code  = prev_code;
  assign bus.pc         = pc;
  assign bus.flush      = flush;
  assign bus.exc_ack    = exc_ack;

  assign bus2.in_valid   = in_valid;
  assign bus2.addr       = addr;
  assign bus2.load_type  = load_type;
  assign bus2.store_type = store_type;
  assign bus2.addr_ov    = addr_ov;
  assign bus2.prev_exc   = prev_exc;
  assign bus2.prev_code  = prev_code;
  assign bus2.pc         = pc;
  assign bus2.flush      = flush;
  assign bus2.exc_ack    = exc_ack;

  mem_exc_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .m(bus)
  );

  mem_exc_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .m(bus2)
  );

  always #5 clk = ~clk;

  int unsigned w_base [4] = '{32'h0, 32'h7f00, 32'h7f10, 32'h7f20};
  int unsigned w_lim  [4] = '{32'h2fff, 32'h7f0b, 32'h7f1b, 32'h7f23};
  bit          w_wo   [4] = '{0, 1, 1, 0};
  bit          w_ro   [4] = '{0, 1, 1, 0};

  // Returns {exception, code} for one M-stage access.
  function automatic logic [5:0] ref_exc(
    input bit pe, input logic [4:0] pcd,
    input int lt, input int st,
    input int unsigned a, input bit ov);
    int w;
    bit inw, wo, ro, bad;
    if (pe) return {1'b1, pcd};
    if (lt != 0 && st != 0) return {1'b1, 5'd10};
    if (lt == 0 && st == 0) return 6'd0;
    w = 4 >> (((lt != 0) ? lt : st) - 1);
    inw = 0; wo = 0; ro = 0;
    for (int i = 0; i < 4; i++)
      if (a >= w_base[i] && a <= w_lim[i]) begin
        inw = 1;
        wo = wo | w_wo[i];
        ro = ro | w_ro[i];
      end
    bad = ov || !inw || (a % w != 0) || (wo && w < 4)
       || (st != 0 && ro && ((a / 4) % 4) == 2);
    if (!bad) return 6'd0;
    return {1'b1, (lt != 0) ? 5'd4 : 5'd5};
  endfunction

  bit          m_hold = 0;
  bit          m_valid = 0;
  logic [4:0]  m_code = 0;
  logic [31:0] m_bad = 0;
  logic [31:0] m_pc = 0;
  int          m_cnt = 0;
  int          m_cnt2 = 0;

  always @(posedge clk or negedge reset) begin
    logic [5:0] r;
    if (!reset) begin
      m_hold = 0; m_valid = 0; m_code = 0;
      m_bad = 0; m_pc = 0; m_cnt = 0; m_cnt2 = 0;
    end else if (!m_hold) begin
      r = ref_exc(prev_exc, prev_code, int'(load_type),
                  int'(store_type), addr, addr_ov);
      if (in_valid && !flush && r[5]) begin
        m_hold = 1; m_valid = 1;
        m_code = r[4:0];
        m_pc = pc;
        if (!prev_exc) m_bad = addr;
        m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end else if (exc_ack) begin
      m_hold = 0; m_valid = 0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m.valid", 64'(bus.exc_valid), 64'(m_valid));
      chk("m.code", 64'(bus.exc_code), 64'(m_code));
      chk("m.bad", 64'(bus.bad_vaddr), 64'(m_bad));
      chk("m.pc", 64'(bus.exc_pc), 64'(m_pc));
      chk("m.busy", 64'(bus.busy), 64'(m_hold));
      chk("m.cnt", 64'(bus.exc_count), 64'(m_cnt));
      chk("m.cnt2", 64'(bus2.exc_count), 64'(m_cnt2));
      chk("m.valid2", 64'(bus2.exc_valid), 64'(m_valid));
      chk("m.code2", 64'(bus2.exc_code), 64'(m_code));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input bit iv, input logic [31:0] a,
                     input logic [1:0] lt, input logic [1:0] st,
                     input logic [31:0] p, input bit pe = 0,
                     input logic [4:0] pcd = 0, input bit fl = 0,
                     input bit ak = 0, input bit ov = 0);
    in_valid = iv; addr = a; load_type = lt; store_type = st;
    pc = p; prev_exc = pe; prev_code = pcd; flush = fl;
    exc_ack = ak; addr_ov = ov;
  endtask

  task automatic ack();
    put(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned pts [8] = '{32'h0, 32'h2fff, 32'h7f00, 32'h7f0b,
                             32'h7f10, 32'h7f1b, 32'h7f20, 32'h7f23};
    int unsigned b;
    b = pts[$urandom_range(0, 7)];
    unique case ($urandom_range(0, 3))
      0: return $urandom;
      1: return $urandom_range(0, 32'h3004);
      default: return b + $urandom_range(0, 8) - 4;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    put(0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    #1 cmp_en = 1'b1;
    chk("rst.valid", 64'(bus.exc_valid), 64'd0);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    put(1, 32'h2ffe, 1, 0, 32'h100);
    step();
    chk("lw.valid", 64'(bus.exc_valid), 64'd1);
    chk("lw.code", 64'(bus.exc_code), 64'd4);
    chk("lw.bad", 64'(bus.bad_vaddr), 64'h2ffe);
    chk("lw.pc", 64'(bus.exc_pc), 64'h100);
    chk("lw.busy", 64'(bus.busy), 64'd1);
    chk("lw.cnt", 64'(bus.exc_count), 64'd1);
    ack();
    chk("ack.valid", 64'(bus.exc_valid), 64'd0);
    chk("ack.busy", 64'(bus.busy), 64'd0);
    chk("ack.bad", 64'(bus.bad_vaddr), 64'h2ffe);

    put(1, 32'h7f08, 0, 1, 32'h104);
    step();
    chk("sw_ro.code", 64'(bus.exc_code), 64'd5);
    ack();
    put(1, 32'h7f04, 0, 1, 32'h108);
    step();
    chk("sw_ok.valid", 64'(bus.exc_valid), 64'd0);
    put(1, 32'h7f04, 3, 0, 32'h10c);
    step();
    chk("lb_wo.code", 64'(bus.exc_code), 64'd4);
    chk("lb_wo.bad", 64'(bus.bad_vaddr), 64'h7f04);
    ack();

    put(1, 32'h3000, 2, 0, 32'h110, 1, 5'd12);
    step();
    chk("prev.code", 64'(bus.exc_code), 64'd12);
    chk("prev.bad", 64'(bus.bad_vaddr), 64'h7f04);
    chk("prev.pc", 64'(bus.exc_pc), 64'h110);
    ack();

    put(0, 32'h2ffe, 1, 0, 32'h114, 0, 0, 0, 1);
    step();
    chk("idle_ack.valid", 64'(bus.exc_valid), 64'd0);
    put(1, 32'h2ffe, 1, 0, 32'h114, 0, 0, 1);
    step();
    chk("flush.valid", 64'(bus.exc_valid), 64'd0);

    put(1, 32'h40, 1, 1, 32'h118);
    step();
    chk("ri.code", 64'(bus.exc_code), 64'd10);
    chk("ri.bad", 64'(bus.bad_vaddr), 64'h40);
    chk("cnt8", 64'(bus.exc_count), 64'd5);
    chk("cnt2.sat", 64'(bus2.exc_count), 64'd3);

    put(1, 32'h2ffe, 1, 0, 32'h200, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold.code", 64'(bus.exc_code), 64'd10);
      chk("hold.bad", 64'(bus.bad_vaddr), 64'h40);
      chk("hold.pc", 64'(bus.exc_pc), 64'h118);
      chk("hold.busy", 64'(bus.busy), 64'd1);
    end
    ack();
    chk("rel.valid", 64'(bus.exc_valid), 64'd0);
    chk("rel.busy", 64'(bus.busy), 64'd0);

    put(1, 32'h1, 1, 0, 32'h300);
    step();
    chk("mis.code", 64'(bus.exc_code), 64'd4);
    #2 reset = 1'b0;
    #1;
    chk("arst.valid", 64'(bus.exc_valid), 64'd0);
    chk("arst.code", 64'(bus.exc_code), 64'd0);
    chk("arst.bad", 64'(bus.bad_vaddr), 64'd0);
    chk("arst.pc", 64'(bus.exc_pc), 64'd0);
    chk("arst.cnt", 64'(bus.exc_count), 64'd0);
    chk("arst.busy", 64'(bus.busy), 64'd0);
    chk("arst.cnt2", 64'(bus2.exc_count), 64'd0);
    #1 reset = 1'b1;
    step();
    chk("first.valid", 64'(bus.exc_valid), 64'd1);
    chk("first.cnt", 64'(bus.exc_count), 64'd1);
    chk("first.bad", 64'(bus.bad_vaddr), 64'h1);
    ack();

    for (int n = 0; n < 3000; n++) begin
      in_valid   = $urandom_range(0, 3) != 0;
      addr       = rnd_addr();
      load_type  = 2'($urandom_range(0, 3));
      store_type = ($urandom_range(0, 2) == 0)
                   ? 2'($urandom_range(0, 3)) : 2'd0;
      addr_ov    = $urandom_range(0, 15) == 0;
      prev_exc   = $urandom_range(0, 9) == 0;
      prev_code  = 5'($urandom);
      pc         = $urandom;
      flush      = $urandom_range(0, 7) == 0;
      exc_ack    = $urandom_range(0, 2) == 0;
      reset      = $urandom_range(0, 299) != 0;
      step();
    end
    reset = 1'b1;
    step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
